cp0_exception_ctrl: RTL and testbench

//  Exception/interrupt sequencer feeding the CP0 register file of the 5-stage pipeline.

---
 rtl/cp0_exception_ctrl.sv | 120 ++++++++++++
 tb/tb_cp0_exception_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cp0_exception_ctrl.sv
// cp0_exception_ctrl: SYSCALL/ERET/IRQ trap sequencer for CP0; define CP0_IRQ_EDGE_EN for sticky edge-latched IRQs
module cp0_exception_ctrl #(
   parameter int          NUM_IRQ      = 4,
   parameter logic [29:0] EXC_VECTOR   = 30'h0000_0060,
   parameter int          FLUSH_CYCLES = 2,
   parameter logic [4:0]  IRQ_CODE     = 5'd0,
   parameter logic [4:0]  SYS_CODE     = 5'd8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         op,
   input  logic [5:0]         func,
   input  logic [4:0]         rs,
   input  logic [4:0]         rt,
   input  logic [4:0]         rd,
   input  logic [4:0]         shamt,
   input  logic               instr_valid,
   input  logic               stall,
   input  logic [29:0]        pc,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               status_ie,
   input  logic               status_exl,
   input  logic [NUM_IRQ-1:0] status_im,
   input  logic [31:0]        epc_in,
   output logic               exc_take,
   output logic [31:0]        epc_out,
   output logic [4:0]         exc_code,
   output logic [2:0]         irq_id,
   output logic               exl_clr,
   output logic               flush,
   output logic               redirect,
   output logic [29:0]        redirect_pc,
   output logic [NUM_IRQ-1:0] irq_pending
);
   typedef enum logic [1:0] {IDLE, TRAP, RET, DRAIN} state_t;
   state_t state;
   logic [2:0] cnt;
   logic ok, sys, ret, found, irq_take;
   logic [2:0] sel;
   logic [NUM_IRQ-1:0] pend_next;
   logic unused_epc_lsb;
   assign unused_epc_lsb = ^epc_in[1:0];
   always_comb begin
      ok = instr_valid & ~stall;
      sys = ok & (op == 6'b000000) & (func == 6'b001100);
      ret = ok & (op == 6'b010000) & (rs == 5'b10000) & (rt == 5'd0) & (rd == 5'd0) &
            (shamt == 5'd0) & (func == 6'b011000);
      found = 1'b0;
      sel = 3'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (irq_pending[i] & status_im[i]) begin
            found = 1'b1;
            sel = 3'(i);
         end
      irq_take = (state == IDLE) & found & status_ie & ~status_exl & ok & ~sys & ~ret;
   end
`ifdef CP0_IRQ_EDGE_EN
   logic [NUM_IRQ-1:0] irq_d, clr;
   assign clr = irq_take ? NUM_IRQ'(1) << sel : '0;
   // a new rising edge wins over the service clear on the same edge
   assign pend_next = (irq_pending & ~clr) | (irq & ~irq_d);
   always_ff @(posedge clk)
      irq_d <= rst ? '0 : irq;
`else
   assign pend_next = irq;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= 3'd0;
         exc_take <= 1'b0;
         epc_out <= 32'd0;
         exc_code <= 5'd0;
         irq_id <= 3'd0;
         exl_clr <= 1'b0;
         flush <= 1'b0;
         redirect <= 1'b0;
         redirect_pc <= 30'd0;
         irq_pending <= '0;
      end else begin
         irq_pending <= pend_next;
         exc_take <= 1'b0;
         epc_out <= 32'd0;
         exc_code <= 5'd0;
         irq_id <= 3'd0;
         exl_clr <= 1'b0;
         redirect <= 1'b0;
         redirect_pc <= 30'd0;
         case (state)
            IDLE:
               if (ret) begin
                  state <= RET;
                  exl_clr <= 1'b1;
                  redirect <= 1'b1;
                  redirect_pc <= epc_in[31:2];
                  flush <= 1'b1;
               end else if (sys | irq_take) begin
                  state <= TRAP;
                  exc_take <= 1'b1;
                  epc_out <= {pc, 2'b00};
                  exc_code <= sys ? SYS_CODE : IRQ_CODE;
                  irq_id <= sys ? 3'd0 : sel;
                  redirect <= 1'b1;
                  redirect_pc <= EXC_VECTOR;
                  flush <= 1'b1;
               end
            TRAP, RET: begin
               state <= DRAIN;
               cnt <= 3'd0;
            end
            default:
               if (cnt == 3'(FLUSH_CYCLES - 1)) begin
                  state <= IDLE;
                  flush <= 1'b0;
               end else
                  cnt <= cnt + 3'd1;
         endcase
      end
   end
endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// tb_cp0_exception_ctrl: randomized check of cp0_exception_ctrl against a cycle-budget reference model
module tb_cp0_exception_ctrl;
   localparam int NI = 4;
   localparam int FC = 2;
   logic clk = 1'b0;
   logic rst;
   logic [5:0] op, func;
   logic [4:0] rs, rt, rd, shamt;
   logic instr_valid, stall, status_ie, status_exl;
   logic [29:0] pc;
   logic [NI-1:0] irq, status_im;
   logic [31:0] epc_in;
   logic exc_take, exl_clr, flush, redirect;
   logic [31:0] epc_out;
   logic [4:0] exc_code;
   logic [2:0] irq_id;
   logic [29:0] redirect_pc;
   logic [NI-1:0] irq_pending;
   int n_vec = 0, n_err = 0;
   // model: flush cycles still owed, pending vector, irq history, expected outputs
   int busy;
   logic [NI-1:0] m_pend, m_irqd;
   logic m_take, m_clr, m_redir;
   logic [31:0] m_epc;
   logic [4:0] m_code;
   logic [2:0] m_id;
   logic [29:0] m_rpc;
   cp0_exception_ctrl dut (
      .clk(clk), .rst(rst), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
      .instr_valid(instr_valid), .stall(stall), .pc(pc), .irq(irq), .status_ie(status_ie),
      .status_exl(status_exl), .status_im(status_im), .epc_in(epc_in), .exc_take(exc_take),
      .epc_out(epc_out), .exc_code(exc_code), .irq_id(irq_id), .exl_clr(exl_clr), .flush(flush),
      .redirect(redirect), .redirect_pc(redirect_pc), .irq_pending(irq_pending)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model();
      bit v, is_sys, is_ret;
      int idx;
      m_take = 0; m_clr = 0; m_redir = 0; m_epc = 0; m_code = 0; m_id = 0; m_rpc = 0;
      if (rst) begin
         busy = 0; m_pend = 0; m_irqd = 0;
      end else begin
         v = instr_valid && !stall;
         is_sys = v && op == 6'd0 && func == 6'd12;
         is_ret = v && op == 6'd16 && rs == 5'd16 && rt == 0 && rd == 0 && shamt == 0 && func == 6'd24;
         idx = -1;
         for (int i = 0; i < NI; i++) if (idx < 0 && m_pend[i] && status_im[i]) idx = i;
         if (busy == 0) begin
            if (is_ret) begin
               m_clr = 1; m_redir = 1; m_rpc = epc_in[31:2]; busy = 1 + FC;
            end else if (is_sys || (idx >= 0 && status_ie && !status_exl && v)) begin
               m_take = 1; m_redir = 1; m_rpc = 30'h60; m_epc = {pc, 2'b00}; busy = 1 + FC;
               m_code = is_sys ? 5'd8 : 5'd0;
               m_id = is_sys ? 3'd0 : 3'(idx);
`ifdef CP0_IRQ_EDGE_EN
               if (!is_sys) m_pend[idx] = 1'b0;
`endif
            end
         end else busy--;
`ifdef CP0_IRQ_EDGE_EN
         m_pend = m_pend | (irq & ~m_irqd);
`else
         m_pend = irq;
`endif
         m_irqd = irq;
      end
   endtask
   task automatic step();
      @(posedge clk);
      model();
      @(negedge clk);
      check("exc_take", 32'(exc_take), 32'(m_take));
      check("exl_clr", 32'(exl_clr), 32'(m_clr));
      check("flush", 32'(flush), 32'(busy > 0));
      check("redirect", 32'(redirect), 32'(m_redir));
      check("irq_pending", 32'(irq_pending), 32'(m_pend));
      if (m_take) begin
         check("epc_out", epc_out, m_epc);
         check("exc_code", 32'(exc_code), 32'(m_code));
         if (m_code == 5'd0) check("irq_id", 32'(irq_id), 32'(m_id));
      end
      if (m_redir) check("redirect_pc", 32'(redirect_pc), 32'(m_rpc));
   endtask
   task automatic set_instr(input int kind);
      op = 6'($urandom); func = 6'($urandom); rs = 5'($urandom);
      rt = 5'($urandom); rd = 5'($urandom); shamt = 5'($urandom);
      if (kind == 1) begin op = 6'd0; func = 6'd12; end
      if (kind >= 2) begin op = 6'd16; rs = 5'd16; rt = 0; rd = 0; shamt = 0; func = 6'd24; end
      if (kind == 3)
         case ($urandom_range(0, 3))
            0: rt = 5'd1;
            1: rd = 5'd4;
            2: shamt = 5'd2;
            default: rs = 5'd0;
         endcase
   endtask
   initial begin
      busy = 0; m_pend = 0; m_irqd = 0;
      rst = 1; set_instr(0); instr_valid = 0; stall = 0; pc = 0; irq = 0;
      status_ie = 0; status_exl = 0; status_im = 0; epc_in = 0;
      step(); step();
      check("rst_flush", 32'(flush), 32'd0);
      check("rst_pending", 32'(irq_pending), 32'd0);
      rst = 0; step();
      set_instr(1); instr_valid = 1; pc = 30'h0000_0C05; stall = 1;
      step();
      check("stall_no_take", 32'(exc_take), 32'd0);
      stall = 0; step();
      check("sys_take", 32'(exc_take), 32'd1);
      check("sys_epc", epc_out, 32'h0000_3014);
      check("sys_code", 32'(exc_code), 32'd8);
      check("sys_vec", 32'(redirect_pc), 32'h60);
      set_instr(0); instr_valid = 0;
      repeat (FC + 1) step();
      check("flush_done", 32'(flush), 32'd0);
      set_instr(2); instr_valid = 1; epc_in = 32'h0000_3018; status_exl = 1;
      step();
      check("eret_clr", 32'(exl_clr), 32'd1);
      check("eret_pc", 32'(redirect_pc), 32'h0000_0C06);
      check("eret_no_take", 32'(exc_take), 32'd0);
      set_instr(0); status_exl = 0; status_ie = 1; status_im = 4'b1111; irq = 4'b0110;
      repeat (FC + 2) step();
      check("irq_id1", 32'(irq_id), 32'd1);
      check("irq_code", 32'(exc_code), 32'd0);
      irq = 0; status_exl = 1;
      repeat (FC + 2) step();
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 59) == 0);
         set_instr($urandom_range(0, 9) < 3 ? 1 : $urandom_range(0, 9) < 2 ? 2 :
                   $urandom_range(0, 9) < 1 ? 3 : 0);
         instr_valid = ($urandom_range(0, 7) != 0);
         stall = ($urandom_range(0, 4) == 0);
         pc = 30'($urandom);
         epc_in = $urandom;
         if ($urandom_range(0, 3) == 0) irq = NI'($urandom);
         status_ie = ($urandom_range(0, 3) != 0);
         status_exl = ($urandom_range(0, 2) == 0);
         status_im = NI'($urandom);
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
